div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative restoring divider for the Mini-SRC datapath. It sits downstream of the adder_subtractor and performs one trial subtract per cycle.
- Produces a quotient and a remainder that feed the LO and HI registers for the DIV instruction.
- The control unit starts it with a one-cycle pulse and waits for done before loading LO/HI.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- div_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- quotient  output  WIDTH  result for LO; registered; holds until the next result write.
- remainder  output  WIDTH  result for HI; registered; holds until the next result write.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid in this cycle.
- div_by_zero  output  1  set with done when divisor was 0; holds until the next result write.

Behaviour:
- Reset: clear=1 asynchronously forces:
  - state=IDLE;
  - quotient, remainder, busy, done, div_by_zero = 0;
  - internal R, Q, D, sign flags = 0.
- Reset mid-operation aborts with no result written. The first start after clear deasserts is accepted normally.
- FSM states: IDLE, ITER, FIX.
- IDLE (edge 0 = the edge sampling start=1):
  - Latch D=|divisor|, Q=|dividend|, R=0 (WIDTH+1 bits).
  - Latch q_neg = div_signed & (dividend[MSB]^divisor[MSB]) and r_neg = div_signed & dividend[MSB].
  - Load iteration counter = WIDTH, set busy=1, go to ITER.
  - Magnitudes are taken only when div_signed=1; otherwise operands are used raw.
- Divide by zero (divisor==0 at edge 0): skip ITER; go to FIX with a zero flag set. Next edge:
  - quotient = all ones;
  - remainder = dividend (raw);
  - div_by_zero=1, done=1, busy=0; return to IDLE.
- ITER, one iteration per edge, edges 1..WIDTH:
  - {R,Q} shifted left 1.
  - trial = R - {0,D} computed (WIDTH+1 bits).
  - If trial MSB==0: R=trial, Q[0]=1. Else R unchanged (shifted), Q[0]=0.
  - Counter decrements; after the WIDTH-th iteration go to FIX.
- FIX, edge WIDTH+1:
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - div_by_zero=0, done=1, busy=0; state=IDLE.
- Latency: done is high in the cycle after edge WIDTH+1 (edge 33 for WIDTH=32); done=0 after edge WIDTH+2. Divide-by-zero: done after edge 1.
- Rounding: truncation toward zero. The remainder sign equals the dividend sign, so dividend = quotient*divisor + remainder.
- Overflow (signed only): most-negative / -1 gives quotient=100…0 (magnitude wraps) and remainder=0. No flag is raised.
- Magnitude edge case: |most-negative| = 100…0 as an unsigned magnitude, handled correctly.
- start while busy (ITER/FIX) is ignored; inputs may change freely during the operation.
- start in the same cycle done is high is accepted, since state is already IDLE. Back-to-back operations are therefore possible with no idle gap.
- quotient, remainder and div_by_zero change only at a FIX edge or on clear.

Test Plan:
- Signed: div_signed=1, 100/7 -> quotient=14, remainder=2, done high after edge 33 only, busy high after edges 0..32.
- Mixed signs: div_signed=1, -100/7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Also 100/-7 -> 0xFFFFFFF2 and 2.
- Unsigned/overflow:
  - div_signed=0, 0xFFFFFFFF/2 -> 0x7FFFFFFF, remainder 1.
  - div_signed=1, 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero: div_signed=1, 1234/0 -> done after edge 1, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1. A following 9/3 -> 3, 0, div_by_zero=0.
- Reset mid-op: start 100/7, pulse clear between edges 10 and 11 -> outputs 0 immediately, no done pulse. A restart of 50/5 -> 10, 0 at edge 33.
- Ignored start:
  - start 20/6, then pulse start with 99/9 at edge 5 -> result 3, 2; second request ignored.
  - start asserted in the done cycle -> accepted; its done arrives 33 edges later.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (one trial subtract per clock).
// Produces quotient (LO) and remainder (HI) for the DIV instruction.
// Ports:
//   clock        - system clock, rising edge
//   clear        - asynchronous active-high reset
//   start        - request pulse, sampled only when idle
//   div_signed   - 1 = two's-complement divide, 0 = unsigned
//   dividend     - numerator, sampled with start
//   divisor      - denominator, sampled with start
//   quotient     - registered result, held until the next result write
//   remainder    - registered result, held until the next result write
//   busy         - high while an operation is in progress
//   done         - one-cycle pulse, results valid in that cycle
//   div_by_zero  - set with done when the divisor was zero
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] r;      // partial remainder; never exceeds the divisor magnitude
    logic [WIDTH-1:0] q;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d;      // divisor magnitude
    logic             q_neg;
    logic             r_neg;
    logic             zero;
    logic [CW-1:0]    cnt;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;

    // Negating the most negative value yields 100..0, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign a_neg = div_signed & dividend[WIDTH-1];
    assign b_neg = div_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // Shift {R,Q} left one place and try subtracting the divisor; a clear
    // borrow bit means the subtract fits.
    assign r_sh  = {r, q[WIDTH-1]};
    assign trial = r_sh - {1'b0, d};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero        <= 1'b0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= '0;
                        d     <= b_mag;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            // Keep the raw dividend: it becomes the remainder.
                            q     <= dividend;
                            zero  <= 1'b1;
                            state <= FIX;
                        end else begin
                            q     <= a_mag;
                            zero  <= 1'b0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (!trial[WIDTH]) begin
                        r <= trial[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= r_sh[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (zero) begin
                        quotient    <= '1;
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? -q : q;
                        remainder   <= r_neg ? -r : r;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test of div_unit against an arithmetic reference
// model, plus literal expectations for each directed vector.
module tb_div_unit;

    localparam int W = 32;

    logic         clock;
    logic         clear;
    logic         start;
    logic         div_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain
    // 64-bit arithmetic (truncating division, remainder follows dividend).
    function automatic logic [2*W:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        longint y;
        longint qq;
        longint rr;
        if (b == '0)
            return {1'b1, {W{1'b1}}, a};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        qq = x / y;
        rr = x % y;
        return {1'b0, qq[W-1:0], rr[W-1:0]};
    endfunction

    // Cycle model: an accepted request completes a fixed number of edges later.
    logic         m_busy;
    logic         m_done;
    logic         m_z;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic [2*W:0] pend;
    int           m_cnt;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_z    <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            pend   <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    pend   <= ref_div(div_signed, dividend, divisor);
                    m_cnt  <= (divisor == '0) ? 1 : W + 1;
                    m_busy <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    {m_z, m_q, m_r} <= pend;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!clear) begin
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_z});
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
        end
    end

    // Issue one request at the current negedge and wait (bounded) for done.
    // Operand inputs are scrambled after the sampling edge.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
        int lat;
        start      = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        @(posedge clock);
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk("busy_after_edge0", {31'b0, busy}, 32'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, exp_lat);
    endtask

    initial begin
        int seen;
        clear      = 1'b1;
        start      = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        #12;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        clear = 1'b0;
        @(negedge clock);

        run_op(1'b1, 32'd100, 32'd7, 33);
        chk("100/7 q", quotient, 32'd14);
        chk("100/7 r", remainder, 32'd2);
        // back-to-back: accepted in the done cycle
        run_op(1'b1, -32'sd100, 32'd7, 33);
        chk("-100/7 q", quotient, 32'hFFFFFFF2);
        chk("-100/7 r", remainder, 32'hFFFFFFFE);
        run_op(1'b1, 32'd100, -32'sd7, 33);
        chk("100/-7 q", quotient, 32'hFFFFFFF2);
        chk("100/-7 r", remainder, 32'd2);
        run_op(1'b0, 32'hFFFFFFFF, 32'd2, 33);
        chk("u max/2 q", quotient, 32'h7FFFFFFF);
        chk("u max/2 r", remainder, 32'd1);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 33);
        chk("ovf q", quotient, 32'h80000000);
        chk("ovf r", remainder, 32'd0);
        run_op(1'b1, 32'd1234, 32'd0, 1);
        chk("div0 q", quotient, 32'hFFFFFFFF);
        chk("div0 r", remainder, 32'd1234);
        chk("div0 flag", {31'b0, div_by_zero}, 32'd1);
        run_op(1'b1, 32'd9, 32'd3, 33);
        chk("9/3 q", quotient, 32'd3);
        chk("9/3 r", remainder, 32'd0);
        chk("9/3 flag", {31'b0, div_by_zero}, 32'd0);

        // Reset in the middle of an operation.
        start      = 1'b1;
        div_signed = 1'b1;
        dividend   = 32'd100;
        divisor    = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1 clear = 1'b1;
        #1;
        chk("clr quotient", quotient, 32'd0);
        chk("clr remainder", remainder, 32'd0);
        chk("clr busy", {31'b0, busy}, 32'd0);
        chk("clr done", {31'b0, done}, 32'd0);
        #1 clear = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        chk("no done after clear", seen, 32'd0);
        run_op(1'b1, 32'd50, 32'd5, 33);
        chk("50/5 q", quotient, 32'd10);
        chk("50/5 r", remainder, 32'd0);

        // A second start while busy must be ignored.
        start      = 1'b1;
        div_signed = 1'b1;
        dividend   = 32'd20;
        divisor    = 32'd6;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        seen  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                start    = 1'b1;
                dividend = 32'd99;
                divisor  = 32'd9;
            end
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                seen = i;
                break;
            end
        end
        chk("ignored start latency", seen, 32'd33);
        chk("20/6 q", quotient, 32'd3);
        chk("20/6 r", remainder, 32'd2);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
